// File: rtl/tex_rom_reader_pkg.sv
// Shared types and constants for the texture SPI flash reader.
package tex_rom_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE,
      GAP
   } state_t;

   localparam logic [7:0] CMD_READ     = 8'h03;
   localparam logic [7:0] CMD_JEDEC_ID = 8'h9F;

   localparam int CMD_BITS      = 8;
   localparam int DEF_DATA_BITS = 6;
   localparam int DEF_ADDR_BITS = 24;

   // Total SPI bits in one read: command, address, then texel data.
   function automatic int xfer_bits(input int addr_bits, input int data_bits);
      return CMD_BITS + addr_bits + data_bits;
   endfunction

endpackage

// File: rtl/tex_rom_reader_if.sv
// Request/response handshake between the texture lookup and the flash reader.
interface tex_rom_reader_if #(
   parameter int DATA_BITS = tex_rom_pkg::DEF_DATA_BITS,
   parameter int ADDR_BITS = tex_rom_pkg::DEF_ADDR_BITS
) ();

   logic                 req;
   logic [ADDR_BITS-1:0] addr;
   logic                 ready;
   logic                 data_valid;
   logic [DATA_BITS-1:0] data;

   modport master (
      output req,
      output addr,
      input  ready,
      input  data_valid,
      input  data
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output data_valid,
      output data
   );

endinterface

// File: rtl/tex_rom_reader_shifter.sv
// Parallel-load SPI shift register: MSB drives io0, io1 enters at the LSB.
// The phase bit marks the sclk-high half of each SPI bit; the register shifts
// on the edge that ends that half. Received bits are only taken while
// capture is high, so the command/address phase shifts in zeros and the MSB
// (the io0 drive) is naturally 0 for the data bits and afterwards.
module tex_spi_shifter #(
   parameter int WIDTH    = 38,
   parameter int TAP_BITS = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_value,
   input  logic                run,
   input  logic                capture,
   input  logic                sin,
   output logic                phase,
   output logic                sout,
   output logic [TAP_BITS-1:0] next_low
);

   logic [WIDTH-1:0] sr;
   logic             sin_gated;

   assign sin_gated = capture & sin;
   assign sout      = sr[WIDTH-1];

   // Low bits as they will be after the pending shift, so the final texel can
   // be registered on the same edge that samples its last bit.
   generate
      if (TAP_BITS == 1) begin : g_tap_one
         assign next_low = sin_gated;
      end else begin : g_tap_many
         assign next_low = {sr[TAP_BITS-2:0], sin_gated};
      end
   endgenerate

   // Load on acceptance, then alternate low/high phases, shifting after each high phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr    <= '0;
         phase <= 1'b0;
      end else if (load) begin
         sr    <= load_value;
         phase <= 1'b0;
      end else if (run) begin
         phase <= ~phase;
         if (phase) begin
            sr <= {sr[WIDTH-2:0], sin_gated};
         end
      end
   end

endmodule

// File: rtl/tex_rom_reader.sv
// Texture flash read sequencer: one 0x03 Read Data transaction per request.
module tex_rom_reader
   import tex_rom_pkg::*;
#(
   parameter int         DATA_BITS = DEF_DATA_BITS,
   parameter int         ADDR_BITS = DEF_ADDR_BITS,
   parameter logic [7:0] READ_CMD  = CMD_READ,
   parameter int         CSB_GAP   = 2
) (
   input  logic              clk,
   input  logic              reset,
   tex_rom_reader_if.slave   bus,
   output logic              tex_csb,
   output logic              tex_sclk,
   output logic              tex_mosi,
   output logic              tex_mosi_oe,
   input  logic              tex_miso
);

   localparam int T     = xfer_bits(ADDR_BITS, DATA_BITS);
   localparam int CNT_W = $clog2(T + 1);
   localparam int GAP_W = $clog2(CSB_GAP + 1);

   state_t               state;
   logic [CNT_W-1:0]     bits_left;
   logic [GAP_W-1:0]     gap_left;
   logic                 phase;
   logic                 accept;
   logic                 run;
   logic                 capture;
   logic [T-1:0]         load_value;
   logic [DATA_BITS-1:0] next_data;

   assign accept     = (state == IDLE) && bus.req;
   assign run        = (state == SHIFT);
   assign capture    = (bits_left <= CNT_W'(DATA_BITS));
   assign load_value = {READ_CMD, bus.addr, {DATA_BITS{1'b0}}};

   tex_spi_shifter #(
      .WIDTH    (T),
      .TAP_BITS (DATA_BITS)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .load_value (load_value),
      .run        (run),
      .capture    (capture),
      .sin        (tex_miso),
      .phase      (phase),
      .sout       (tex_mosi),
      .next_low   (next_data)
   );

   // Transaction FSM with registered handshake and SPI control outputs.
   // DONE is the first CS#-high cycle after the transfer and the acceptance
   // cycle of the next request is the last, so GAP covers what lies between.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bits_left      <= '0;
         gap_left       <= '0;
         bus.ready      <= 1'b1;
         bus.data_valid <= 1'b0;
         bus.data       <= '0;
         tex_csb        <= 1'b1;
         tex_sclk       <= 1'b0;
         tex_mosi_oe    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req) begin
                  state       <= SHIFT;
                  bits_left   <= CNT_W'(T);
                  bus.ready   <= 1'b0;
                  tex_csb     <= 1'b0;
                  tex_sclk    <= 1'b0;
                  tex_mosi_oe <= 1'b1;
               end
            end
            SHIFT: begin
               if (!phase) begin
                  tex_sclk <= 1'b1;
               end else begin
                  tex_sclk  <= 1'b0;
                  bits_left <= bits_left - 1'b1;
                  if (bits_left == CNT_W'(1)) begin
                     state          <= DONE;
                     tex_csb        <= 1'b1;
                     tex_mosi_oe    <= 1'b0;
                     bus.data_valid <= 1'b1;
                     bus.data       <= next_data;
                  end else begin
                     tex_mosi_oe <= (bits_left > CNT_W'(DATA_BITS + 1));
                  end
               end
            end
            DONE: begin
               bus.data_valid <= 1'b0;
               if (CSB_GAP <= 2) begin
                  state     <= IDLE;
                  bus.ready <= 1'b1;
               end else begin
                  state    <= GAP;
                  gap_left <= GAP_W'(CSB_GAP - 2);
               end
            end
            GAP: begin
               if (gap_left <= GAP_W'(1)) begin
                  state     <= IDLE;
                  bus.ready <= 1'b1;
               end else begin
                  gap_left <= gap_left - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tex_rom_reader.sv
// Scoreboard bench for tex_rom_reader with a behavioural SPI flash model.
module tb_tex_rom_reader;
   import tex_rom_pkg::*;

   localparam int DATA_BITS = 6;
   localparam int ADDR_BITS = 24;
   localparam int CSB_GAP   = 2;
   localparam int T         = 8 + ADDR_BITS + DATA_BITS;
   localparam int PERIOD    = 2 * T + CSB_GAP;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic tex_miso = 1'b0;
   logic tex_csb;
   logic tex_sclk;
   logic tex_mosi;
   logic tex_mosi_oe;

   tex_rom_reader_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

   tex_rom_reader #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS),
      .READ_CMD  (8'h03),
      .CSB_GAP   (CSB_GAP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .tex_csb     (tex_csb),
      .tex_sclk    (tex_sclk),
      .tex_mosi    (tex_mosi),
      .tex_mosi_oe (tex_mosi_oe),
      .tex_miso    (tex_miso)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference model state: cycle counter, busy window, expected responses.
   int                   cyc       = 0;
   bit                   busy      = 1'b0;
   int                   acc_cyc   = 0;
   logic [23:0]          acc_addr  = '0;
   int                   acc_count = 0;
   int                   skip_to   = 0;
   logic [DATA_BITS-1:0] exp_q[$];
   logic [31:0]          word_q[$];

   // Monitor state.
   int                   rd_idx    = 0;
   logic [DATA_BITS-1:0] data_hold = '0;
   bit                   check_on  = 1'b0;

   // Flash model state.
   int          fl_bits   = 0;
   int          fl_rises  = 0;
   logic [31:0] fl_word   = '0;
   logic        prev_csb  = 1'b1;
   logic        prev_sclk = 1'b0;

   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      case (a)
         24'h000040: return 8'hA5;
         24'h000000: return 8'hFC;
         24'h000001: return 8'h03;
         default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [DATA_BITS-1:0] ref_texel(input logic [23:0] a);
      logic [7:0] b;
      b = flash_byte(a);
      return b[7:8-DATA_BITS];
   endfunction

   function automatic int pending();
      int base;
      base = (rd_idx < skip_to) ? skip_to : rd_idx;
      return exp_q.size() - base;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: a request is taken whenever the reader is not inside
   // its 2T+CSB_GAP cycle busy window; reset abandons anything in flight.
   always @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         skip_to <= exp_q.size();
      end else if (bus.req && !busy) begin
         busy      <= 1'b1;
         acc_cyc   <= cyc;
         acc_addr  <= bus.addr;
         acc_count <= acc_count + 1;
         exp_q.push_back(ref_texel(bus.addr));
         word_q.push_back({CMD_READ, bus.addr});
      end else if (busy && (cyc + 1 - acc_cyc) >= PERIOD) begin
         busy <= 1'b0;
      end
      cyc <= cyc + 1;
   end

   // Flash model: samples io0 on rising SCLK, shifts the addressed byte out
   // MSB first on falling SCLK once command and address are complete.
   always @(tex_csb, tex_sclk) begin : flash_model
      logic [7:0] b;
      int         i;
      if (prev_csb === 1'b1 && tex_csb === 1'b0) begin
         fl_bits  = 0;
         fl_rises = 0;
         fl_word  = '0;
      end
      if (prev_csb === 1'b0 && tex_csb === 1'b1) begin
         tex_miso = 1'b0;
      end
      if (tex_csb === 1'b0 && prev_sclk === 1'b0 && tex_sclk === 1'b1) begin
         fl_rises = fl_rises + 1;
         if (fl_bits < 32) fl_word = {fl_word[30:0], tex_mosi};
         fl_bits = fl_bits + 1;
      end
      if (tex_csb === 1'b0 && prev_sclk === 1'b1 && tex_sclk === 1'b0 && fl_bits >= 32) begin
         b = flash_byte(fl_word[23:0]);
         i = fl_bits - 32;
         tex_miso = (fl_word[31:24] == 8'h03 && i < 8) ? b[7-i] : 1'b0;
      end
      prev_csb  = tex_csb;
      prev_sclk = tex_sclk;
   end

   // Monitor: per-cycle pin timing against the model, scoreboard pop on data_valid.
   always @(negedge clk) begin : monitor
      int          p;
      int          bit_idx;
      int          idx;
      bit          in_x;
      logic [31:0] word;
      logic        exp_mosi;
      logic        exp_oe;
      if (check_on) begin
         p       = cyc - acc_cyc;
         in_x    = busy && p >= 1 && p <= 2 * T;
         bit_idx = (p - 1) / 2;
         word    = {CMD_READ, acc_addr};
         exp_oe  = in_x && bit_idx < 32;
         exp_mosi = exp_oe ? word[31 - bit_idx] : 1'b0;
         checkOutput("ready",       bus.ready,   !busy);
         checkOutput("tex_csb",     tex_csb,     !in_x);
         checkOutput("tex_sclk",    tex_sclk,    in_x && (p % 2 == 0));
         checkOutput("tex_mosi_oe", tex_mosi_oe, exp_oe);
         checkOutput("tex_mosi",    tex_mosi,    exp_mosi);
         checkOutput("sclk_only_with_csb_low", tex_sclk & tex_csb, 1'b0);
         checkOutput("data_valid",  bus.data_valid, busy && p == 2 * T + 1);
         idx = (rd_idx < skip_to) ? skip_to : rd_idx;
         if (bus.data_valid === 1'b1) begin
            checkOutput("outstanding_at_valid", (idx < exp_q.size()), 1'b1);
            if (idx < exp_q.size()) begin
               checkOutput("texel",          bus.data, exp_q[idx]);
               checkOutput("flash_cmd_addr", fl_word,  word_q[idx]);
               checkOutput("sclk_rises",     fl_rises, T);
               data_hold <= exp_q[idx];
               idx = idx + 1;
            end
         end else begin
            checkOutput("data_hold", bus.data, data_hold);
         end
         rd_idx <= idx;
      end
      if (reset) data_hold <= '0;
   end

   task automatic applyStimulus(input logic [23:0] a, input bit hold_req);
      int start;
      int waited;
      start  = acc_count;
      waited = 0;
      bus.addr = a;
      bus.req  = 1'b1;
      while (acc_count == start && waited < 2 * PERIOD) begin
         @(negedge clk);
         waited++;
      end
      if (!hold_req) bus.req = 1'b0;
   endtask

   task automatic waitIdle();
      int w;
      w = 0;
      while ((busy || pending() != 0) && w < 4 * PERIOD) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [23:0] a;
      bus.req  = 1'b0;
      bus.addr = '0;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      check_on = 1'b1;

      $display("[TB] idle after reset");
      repeat (20) @(negedge clk);

      $display("[TB] single read at 0x000040");
      applyStimulus(24'h000040, 1'b0);
      waitIdle();

      $display("[TB] back-to-back reads with req held high");
      applyStimulus(24'h000000, 1'b1);
      applyStimulus(24'h000001, 1'b0);
      waitIdle();

      $display("[TB] reset during a transfer");
      applyStimulus(24'h000040, 1'b0);
      while (cyc - acc_cyc < 40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      applyStimulus(24'h000040, 1'b0);
      waitIdle();

      $display("[TB] request and address change while busy");
      applyStimulus(24'h00_12_34, 1'b0);
      while (cyc - acc_cyc < 30) @(negedge clk);
      bus.addr = 24'($urandom);
      bus.req  = 1'b1;
      @(negedge clk);
      bus.req  = 1'b0;
      waitIdle();

      $display("[TB] randomized requests");
      for (int n = 0; n < 12; n++) begin
         a = ($urandom_range(0, 3) == 0) ? 24'h000040 : 24'($urandom);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         applyStimulus(a, bit'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 60)) @(negedge clk);
         bus.addr = 24'($urandom);
      end
      bus.req = 1'b0;
      waitIdle();

      checkOutput("scoreboard_drained", pending(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
